// File: rtl/xpyxmy_acc_if.sv
// Bus between the (X+Y)(X-Y) product stage and the block accumulator:
// product samples in, block statistics out.
interface xpyxmy_acc_if #(
    parameter int W  = 32,
    parameter int SW = W + 8
);
    // in_valid qualifies D for exactly the cycle it is high; there is no
    // backpressure, so every valid sample is taken on that rising edge.
    // out_valid is a one-cycle pulse marking sum/maxv/minv/cnt as final.
    logic                 in_valid;
    logic signed [W-1:0]  D;
    logic        [7:0]    N;
    logic                 clr;
    logic                 busy;
    logic                 out_valid;
    logic signed [SW-1:0] sum;
    logic signed [W-1:0]  maxv;
    logic signed [W-1:0]  minv;
    logic        [8:0]    cnt;

    modport master (
        output in_valid, D, N, clr,
        input  busy, out_valid, sum, maxv, minv, cnt
    );

    modport slave (
        input  in_valid, D, N, clr,
        output busy, out_valid, sum, maxv, minv, cnt
    );
endinterface

// File: rtl/xpyxmy_acc.sv
// Block accumulator: sums N signed products and tracks their max, min and
// count, pulsing out_valid once per completed block.
module xpyxmy_acc #(
    parameter int W  = 32,
    parameter int SW = W + 8
) (
    input  logic         clk,
    input  logic         rst_n,
    xpyxmy_acc_if.slave  bus,
    output logic [1:0]   dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [8:0]  nq;
    logic [8:0]  n_eff;
    logic [8:0]  cnt_inc;
    logic signed [SW-1:0] d_ext;

    // A block length of 0 encodes the full 256-sample block.
    assign n_eff     = (bus.N == 8'd0) ? 9'd256 : {1'b0, bus.N};
    assign cnt_inc   = bus.cnt + 9'd1;
    assign d_ext     = {{(SW-W){bus.D[W-1]}}, bus.D};
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            nq            <= 9'd256;
            bus.sum       <= '0;
            bus.maxv      <= '0;
            bus.minv      <= '0;
            bus.cnt       <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else if (bus.clr) begin
            state         <= IDLE;
            bus.sum       <= '0;
            bus.maxv      <= '0;
            bus.minv      <= '0;
            bus.cnt       <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // A sample landing in DONE opens the next block directly.
                    if (bus.in_valid) begin
                        nq       <= n_eff;
                        bus.sum  <= d_ext;
                        bus.maxv <= bus.D;
                        bus.minv <= bus.D;
                        bus.cnt  <= 9'd1;
                        if (n_eff == 9'd1) begin
                            state         <= DONE;
                            bus.out_valid <= 1'b1;
                            bus.busy      <= 1'b0;
                        end else begin
                            state         <= ACC;
                            bus.out_valid <= 1'b0;
                            bus.busy      <= 1'b1;
                        end
                    end else begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                    end
                end
                ACC: begin
                    if (bus.in_valid) begin
                        bus.sum <= bus.sum + d_ext;
                        bus.cnt <= cnt_inc;
                        if (bus.D > bus.maxv) bus.maxv <= bus.D;
                        if (bus.D < bus.minv) bus.minv <= bus.D;
                        if (cnt_inc == nq) begin
                            state         <= DONE;
                            bus.out_valid <= 1'b1;
                            bus.busy      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_xpyxmy_acc.sv
// Directed bench for xpyxmy_acc: hand-computed block results, stream
// continuity, clear and asynchronous reset behaviour.
module tb_xpyxmy_acc;
    localparam int W  = 32;
    localparam int SW = 40;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    int pulses;
    logic signed [SW-1:0] exp_q[$];
    logic signed [63:0]   exp_big;

    xpyxmy_acc_if #(.W(W), .SW(SW)) bus ();

    xpyxmy_acc #(.W(W), .SW(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sum"},  bus.sum,       0);
        check({tag, "_maxv"}, bus.maxv,      0);
        check({tag, "_minv"}, bus.minv,      0);
        check({tag, "_cnt"},  bus.cnt,       0);
        check({tag, "_ov"},   bus.out_valid, 0);
        check({tag, "_busy"}, bus.busy,      0);
        check({tag, "_st"},   dbg_state,     0);
    endtask

    // driver: one sample accepted per call; outputs sampled 1 ns after the edge
    task automatic send(input logic signed [W-1:0] d);
        bus.in_valid = 1'b1;
        bus.D        = d;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        automatic int v12[12] = '{100, 99, 96, 91, 84, 75, 64, 51, 36, 19, 0, -21};
        automatic int v4[4]   = '{5, -3, 7, 1};

        bus.in_valid = 1'b0;
        bus.D        = '0;
        bus.N        = 8'd0;
        bus.clr      = 1'b0;
        rst_n        = 1'b0;
        #1;
        check_zero("reset");
        #20;
        rst_n = 1'b1;
        idle(2);
        check_zero("post_reset_idle");

        // 12-sample block, N changed mid-block must be ignored
        bus.N = 8'd12;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) bus.N = 8'd3;
            send(v12[i]);
            if (i == 10) begin
                check("b12_busy_11", bus.busy, 1);
                check("b12_ov_11", bus.out_valid, 0);
                check("b12_cnt_11", bus.cnt, 11);
            end
        end
        check("b12_ov", bus.out_valid, 1);
        check("b12_busy", bus.busy, 0);
        check("b12_st", dbg_state, 2);
        check("b12_sum", bus.sum, 694);
        check("b12_maxv", bus.maxv, 100);
        check("b12_minv", bus.minv, -21);
        check("b12_cnt", bus.cnt, 12);
        idle(1);
        check("b12_ov_drop", bus.out_valid, 0);
        check("b12_hold_sum", bus.sum, 694);
        check("b12_st_idle", dbg_state, 0);

        // 4-sample block with 2-cycle gaps
        bus.N = 8'd4;
        for (int i = 0; i < 4; i++) begin
            send(v4[i]);
            if (i < 3) begin
                check("gap_ov", bus.out_valid, 0);
                idle(2);
                check("gap_ov_idle", bus.out_valid, 0);
                check("gap_busy", bus.busy, 1);
            end
        end
        check("b4_ov", bus.out_valid, 1);
        check("b4_sum", bus.sum, 10);
        check("b4_maxv", bus.maxv, 7);
        check("b4_minv", bus.minv, -3);
        check("b4_cnt", bus.cnt, 4);
        idle(1);

        // back-to-back N=2 blocks through the scoreboard
        bus.N = 8'd2;
        exp_q.push_back(40'sd3);
        exp_q.push_back(40'sd7);
        pulses = 0;
        for (int i = 1; i <= 4; i++) begin
            send(i);
            if (bus.out_valid) begin
                pulses++;
                if (exp_q.size() > 0) check("stream_sum", bus.sum, exp_q.pop_front());
            end
            if (i == 3) begin
                check("stream_s3_cnt", bus.cnt, 1);
                check("stream_s3_sum", bus.sum, 3);
                check("stream_s3_busy", bus.busy, 1);
            end
        end
        check("stream_pulses", pulses, 2);
        check("stream_q_empty", exp_q.size(), 0);
        idle(1);

        // 256 samples of the most negative value
        bus.N = 8'd0;
        for (int i = 0; i < 256; i++) begin
            send(32'sh8000_0000);
            if (i == 254) begin
                check("full_ov_255", bus.out_valid, 0);
                check("full_cnt_255", bus.cnt, 255);
            end
        end
        exp_big = -(64'sd1 <<< 39);
        check("full_ov", bus.out_valid, 1);
        check("full_sum", bus.sum, exp_big);
        check("full_cnt", bus.cnt, 256);
        check("full_maxv", bus.maxv, -64'sd2147483648);
        check("full_minv", bus.minv, -64'sd2147483648);
        idle(1);

        // clear mid-block wins over a valid sample
        bus.N = 8'd8;
        send(11); send(12); send(13);
        bus.clr = 1'b1;
        send(55);
        bus.clr = 1'b0;
        check_zero("clr");
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            if (bus.out_valid) pulses++;
        end
        check("clr_no_ov", pulses, 0);
        bus.N = 8'd1;
        send(9);
        check("n1_ov", bus.out_valid, 1);
        check("n1_sum", bus.sum, 9);
        check("n1_cnt", bus.cnt, 1);
        idle(1);

        // asynchronous reset mid-period discards the partial block
        bus.N = 8'd5;
        send(4); send(6);
        check("rst_pre_busy", bus.busy, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        #10;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            if (bus.out_valid || bus.busy) pulses++;
        end
        check("rst_quiet", pulses, 0);
        bus.N = 8'd5;
        send(2);
        check("rst_new_busy", bus.busy, 1);
        check("rst_new_cnt", bus.cnt, 1);
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
